xdma_nd_addr_gen: RTL and testbench

// Parametrised N-dimensional, multi-destination address generator for the XDMA data path.
// - Accepts one descriptor per transfer: a base address per broadcast destination, temporal

---
 rtl/xdma_nd_addr_gen.sv | 128 ++++++++++++
 tb/tb_xdma_nd_addr_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_nd_addr_gen.sv
// N-dimensional, multi-destination address generator: walks a mixed-radix loop nest
// and emits NrBroadcast addresses per valid/ready beat.
module xdma_nd_addr_gen #(
  parameter int unsigned AddrWidth   = 48,
  parameter int unsigned BoundWidth  = 19,
  parameter int unsigned StrideWidth = 19,
  parameter int unsigned NrDimension = 6,
  parameter int unsigned NrBroadcast = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               cfg_valid_i,
  output logic                               cfg_ready_o,
  input  logic [NrBroadcast*AddrWidth-1:0]   cfg_base_i,
  input  logic [NrDimension*BoundWidth-1:0]  cfg_bound_i,
  input  logic [NrDimension*StrideWidth-1:0] cfg_stride_i,
  input  logic [NrBroadcast-1:0]             cfg_dest_en_i,
  output logic                               addr_valid_o,
  input  logic                               addr_ready_i,
  output logic [NrBroadcast*AddrWidth-1:0]   addr_o,
  output logic [NrBroadcast-1:0]             dest_en_o,
  output logic                               addr_last_o,
  output logic                               done_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                               state_q, state_d;
  logic [NrBroadcast*AddrWidth-1:0]         base_q;
  logic [NrDimension*BoundWidth-1:0]        bound_q;
  logic [NrDimension*StrideWidth-1:0]       stride_q;
  logic [NrBroadcast-1:0]                   dest_en_q;
  logic [NrDimension-1:0][BoundWidth-1:0]   cnt_q, cnt_d;
  logic [NrDimension-1:0][AddrWidth-1:0]    off_q, off_d;
  logic [NrDimension-1:0][AddrWidth-1:0]    stride_ext;
  logic [NrDimension-1:0]                   at_max, step, wrap, cfg_bound_zero;
  logic [NrDimension:0]                     carry;
  logic [AddrWidth-1:0]                     off_sum;
  logic                                     cfg_hs, addr_hs;

  assign cfg_ready_o  = (state_q == StIdle);
  assign addr_valid_o = (state_q == StRun);
  assign done_o       = (state_q == StDone);
  assign addr_last_o  = addr_valid_o & carry[NrDimension];
  assign dest_en_o    = dest_en_q;

  // clear_i wins over any handshake in the same cycle.
  assign cfg_hs  = cfg_valid_i & cfg_ready_o & ~clear_i;
  assign addr_hs = addr_valid_o & addr_ready_i & ~clear_i;

  // Carry chain: a dimension steps only when every inner dimension sits at its maximum.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < NrDimension; gi++) begin : g_dim
    assign at_max[gi]         = cnt_q[gi] == (bound_q[gi*BoundWidth +: BoundWidth] - BoundWidth'(1));
    assign carry[gi+1]        = carry[gi] & at_max[gi];
    assign step[gi]           = carry[gi] & ~at_max[gi];
    assign wrap[gi]           = carry[gi] & at_max[gi];
    assign stride_ext[gi]     = AddrWidth'(stride_q[gi*StrideWidth +: StrideWidth]);
    assign cfg_bound_zero[gi] = (cfg_bound_i[gi*BoundWidth +: BoundWidth] == '0);
  end

  always_comb begin
    off_sum = '0;
    for (int d = 0; d < NrDimension; d++) begin
      off_sum = off_sum + off_q[d];
    end
  end

  for (genvar gi = 0; gi < NrBroadcast; gi++) begin : g_dest
    assign addr_o[gi*AddrWidth +: AddrWidth] = base_q[gi*AddrWidth +: AddrWidth] + off_sum;
  end

  always_comb begin
    cnt_d = cnt_q;
    off_d = off_q;
    if (cfg_hs) begin
      cnt_d = '0;
      off_d = '0;
    end else if (addr_hs) begin
      for (int d = 0; d < NrDimension; d++) begin
        if (step[d]) begin
          cnt_d[d] = cnt_q[d] + BoundWidth'(1);
          off_d[d] = off_q[d] + stride_ext[d];
        end else if (wrap[d]) begin
          cnt_d[d] = '0;
          off_d[d] = '0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cfg_hs) state_d = (|cfg_bound_zero) ? StDone : StRun;
      StRun:   if (addr_hs && addr_last_o) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      base_q    <= '0;
      bound_q   <= '0;
      stride_q  <= '0;
      dest_en_q <= '0;
      cnt_q     <= '0;
      off_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      if (cfg_hs) begin
        base_q    <= cfg_base_i;
        bound_q   <= cfg_bound_i;
        stride_q  <= cfg_stride_i;
        dest_en_q <= cfg_dest_en_i;
      end
    end
  end

endmodule

// File: tb/tb_xdma_nd_addr_gen.sv
// Scoreboard bench for xdma_nd_addr_gen: stimulus queues expected beats, a monitor pops
// and compares every accepted beat and checks done/backpressure behaviour.
module tb_xdma_nd_addr_gen;

  localparam int AW = 48;
  localparam int BW = 19;
  localparam int SW = 19;
  localparam int ND = 6;
  localparam int NB = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                clear_i;
  logic                cfg_valid_i;
  logic                cfg_ready_o;
  logic [NB*AW-1:0]    cfg_base_i;
  logic [ND*BW-1:0]    cfg_bound_i;
  logic [ND*SW-1:0]    cfg_stride_i;
  logic [NB-1:0]       cfg_dest_en_i;
  logic                addr_valid_o;
  logic                addr_ready_i;
  logic [NB*AW-1:0]    addr_o;
  logic [NB-1:0]       dest_en_o;
  logic                addr_last_o;
  logic                done_o;

  logic [AW-1:0] base_a   [NB];
  logic [BW-1:0] bound_a  [ND];
  logic [SW-1:0] stride_a [ND];

  typedef struct {
    logic [NB*AW-1:0] addr;
    logic             last;
    logic [NB-1:0]    de;
  } beat_t;

  beat_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int stall_cnt = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    cfg_base_i   = '0;
    cfg_bound_i  = '0;
    cfg_stride_i = '0;
    for (int k = 0; k < NB; k++) cfg_base_i[k*AW +: AW] = base_a[k];
    for (int d = 0; d < ND; d++) begin
      cfg_bound_i[d*BW +: BW]  = bound_a[d];
      cfg_stride_i[d*SW +: SW] = stride_a[d];
    end
  end

  xdma_nd_addr_gen #(
    .AddrWidth(AW), .BoundWidth(BW), .StrideWidth(SW), .NrDimension(ND), .NrBroadcast(NB)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_base_i    (cfg_base_i),
    .cfg_bound_i   (cfg_bound_i),
    .cfg_stride_i  (cfg_stride_i),
    .cfg_dest_en_i (cfg_dest_en_i),
    .addr_valid_o  (addr_valid_o),
    .addr_ready_i  (addr_ready_i),
    .addr_o        (addr_o),
    .dest_en_o     (dest_en_o),
    .addr_last_o   (addr_last_o),
    .done_o        (done_o)
  );

  task automatic chk(input string name, input logic [NB*AW-1:0] act, input logic [NB*AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_desc();
    for (int k = 0; k < NB; k++) base_a[k] = '0;
    for (int d = 0; d < ND; d++) begin
      bound_a[d]  = BW'(1);
      stride_a[d] = '0;
    end
    cfg_dest_en_i = 4'hF;
  endtask

  task automatic set_base_all(input logic [AW-1:0] b);
    for (int k = 0; k < NB; k++) base_a[k] = b;
  endtask

  task automatic push4(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] a3, input logic last, input logic [NB-1:0] de);
    beat_t b;
    b.addr = {a3, a2, a1, a0};
    b.last = last;
    b.de   = de;
    exp_q.push_back(b);
  endtask

  task automatic push1(input logic [AW-1:0] a, input logic last);
    push4(a, a, a, a, last, 4'hF);
  endtask

  task automatic send_cfg();
    logic hs;
    hs = 1'b0;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      hs = cfg_ready_o && !clear_i;
      @(posedge clk_i); #1;
      if (hs) break;
    end
    cfg_valid_i = 1'b0;
    chk("cfg_accept", {191'd0, hs}, {191'd0, 1'b1});
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i); #1;
      if (done_cnt != start) break;
    end
    chk("done_seen", (NB*AW)'(done_cnt - start), (NB*AW)'(1));
    chk("queue_drained", (NB*AW)'(exp_q.size()), '0);
  endtask

  // Monitor: compares every accepted beat and the done pulse against the scoreboard.
  initial begin
    logic stall_prev, clear_prev, last_hs_prev, cfg_hs_prev, cfg_hs_prev2, done_prev;
    logic [NB*AW-1:0] held_addr;
    logic held_last;
    logic [NB-1:0] held_de;
    beat_t e;
    stall_prev = 0; clear_prev = 0; last_hs_prev = 0; cfg_hs_prev = 0; cfg_hs_prev2 = 0;
    done_prev = 0; held_addr = '0; held_last = 0; held_de = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni !== 1'b1) begin
        stall_prev = 0; clear_prev = 0; last_hs_prev = 0; cfg_hs_prev = 0; cfg_hs_prev2 = 0;
        done_prev = 0;
        continue;
      end
      if (stall_prev && !clear_prev) begin
        n_cmp++;
        if (!addr_valid_o || addr_o !== held_addr || addr_last_o !== held_last || dest_en_o !== held_de) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b addr=%0h last=%0b de=%0h expected valid=1 addr=%0h last=%0b de=%0h",
                   addr_valid_o, addr_o, addr_last_o, dest_en_o, held_addr, held_last, held_de);
        end
      end
      if (addr_valid_o && addr_ready_i && !clear_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got addr=%0h last=%0b expected no beat", addr_o, addr_last_o);
        end else begin
          e = exp_q.pop_front();
          if (addr_o !== e.addr || addr_last_o !== e.last || dest_en_o !== e.de) begin
            n_err++;
            $display("FAIL beat: got addr=%0h last=%0b de=%0h expected addr=%0h last=%0b de=%0h",
                     addr_o, addr_last_o, dest_en_o, e.addr, e.last, e.de);
          end
        end
      end
      if (done_o) begin
        n_cmp++;
        if (!(last_hs_prev || cfg_hs_prev || cfg_hs_prev2) || done_prev || cfg_ready_o) begin
          n_err++;
          $display("FAIL done_pulse: got done after_last=%0b after_cfg=%0b prev_done=%0b cfg_ready=%0b expected after_last_or_cfg=1 prev_done=0 cfg_ready=0",
                   last_hs_prev, cfg_hs_prev || cfg_hs_prev2, done_prev, cfg_ready_o);
        end
        done_cnt++;
      end
      if (addr_valid_o) valid_cnt++;
      if (addr_valid_o && !addr_ready_i) stall_cnt++;
      stall_prev   = addr_valid_o && !addr_ready_i;
      clear_prev   = clear_i;
      held_addr    = addr_o;
      held_last    = addr_last_o;
      held_de      = dest_en_o;
      last_hs_prev = addr_valid_o && addr_ready_i && addr_last_o && !clear_i;
      cfg_hs_prev2 = cfg_hs_prev;
      cfg_hs_prev  = cfg_valid_i && cfg_ready_o && !clear_i;
      done_prev    = done_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_v, snap_s, snap_d;
    rst_ni = 1'b0;
    clear_i = 1'b0;
    cfg_valid_i = 1'b0;
    addr_ready_i = 1'b1;
    reset_desc();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_cfg_ready", {191'd0, cfg_ready_o}, {191'd0, 1'b1});
    chk("rst_addr_valid", {191'd0, addr_valid_o}, '0);
    chk("rst_addr_last", {191'd0, addr_last_o}, '0);
    chk("rst_done", {191'd0, done_o}, '0);
    chk("rst_addr", addr_o, '0);
    chk("rst_dest_en", {188'd0, dest_en_o}, '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // One dimension
    reset_desc();
    set_base_all(48'h1000);
    bound_a[0] = 19'd4; stride_a[0] = 19'h40;
    push1(48'h1000, 0); push1(48'h1040, 0); push1(48'h1080, 0); push1(48'h10C0, 1);
    send_cfg();
    wait_done();

    // Two dimensions
    reset_desc();
    bound_a[0] = 19'd2; stride_a[0] = 19'h10;
    bound_a[1] = 19'd3; stride_a[1] = 19'h200;
    push1(48'h0, 0); push1(48'h10, 0); push1(48'h200, 0);
    push1(48'h210, 0); push1(48'h400, 0); push1(48'h410, 1);
    send_cfg();
    wait_done();

    // Broadcast with partial destination mask
    reset_desc();
    base_a[0] = 48'h0; base_a[1] = 48'h1000; base_a[2] = 48'h2000; base_a[3] = 48'h3000;
    cfg_dest_en_i = 4'b0101;
    bound_a[0] = 19'd2; stride_a[0] = 19'h8;
    bound_a[1] = 19'd2; stride_a[1] = 19'h100;
    push4(48'h000, 48'h1000, 48'h2000, 48'h3000, 0, 4'b0101);
    push4(48'h008, 48'h1008, 48'h2008, 48'h3008, 0, 4'b0101);
    push4(48'h100, 48'h1100, 48'h2100, 48'h3100, 0, 4'b0101);
    push4(48'h108, 48'h1108, 48'h2108, 48'h3108, 1, 4'b0101);
    send_cfg();
    wait_done();

    // Backpressure: three stalled cycles after two beats
    reset_desc();
    set_base_all(48'h500);
    bound_a[0] = 19'd6; stride_a[0] = 19'h8;
    push1(48'h500, 0); push1(48'h508, 0); push1(48'h510, 0);
    push1(48'h518, 0); push1(48'h520, 0); push1(48'h528, 1);
    snap_s = stall_cnt;
    send_cfg();
    repeat (2) @(posedge clk_i); #1;
    addr_ready_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    addr_ready_i = 1'b1;
    wait_done();
    chk("stall_cycles", (NB*AW)'(stall_cnt - snap_s), (NB*AW)'(3));

    // Zero bound in dimension 2: no beats, done still pulses
    reset_desc();
    bound_a[2] = 19'd0;
    snap_v = valid_cnt;
    send_cfg();
    wait_done();
    repeat (3) @(negedge clk_i); #1;
    chk("zero_bound_no_valid", (NB*AW)'(valid_cnt - snap_v), '0);

    // Address wrap-around
    reset_desc();
    set_base_all(48'hFFFF_FFFF_FFE0);
    bound_a[0] = 19'd4; stride_a[0] = 19'h10;
    push1(48'hFFFF_FFFF_FFE0, 0); push1(48'hFFFF_FFFF_FFF0, 0);
    push1(48'h0, 0); push1(48'h10, 1);
    send_cfg();
    wait_done();

    // Same descriptor aborted by clear at beat 2
    push1(48'hFFFF_FFFF_FFE0, 0); push1(48'hFFFF_FFFF_FFF0, 0);
    snap_d = done_cnt;
    send_cfg();
    repeat (2) @(posedge clk_i); #1;
    addr_ready_i = 1'b0;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    addr_ready_i = 1'b1;
    @(negedge clk_i); #1;
    chk("clear_valid_low", {191'd0, addr_valid_o}, '0);
    chk("clear_cfg_ready", {191'd0, cfg_ready_o}, {191'd0, 1'b1});
    repeat (4) @(negedge clk_i); #1;
    chk("clear_no_done", (NB*AW)'(done_cnt - snap_d), '0);
    chk("clear_queue_drained", (NB*AW)'(exp_q.size()), '0);

    // Recovery after abort
    reset_desc();
    set_base_all(48'h40);
    bound_a[0] = 19'd2; stride_a[0] = 19'h4;
    push1(48'h40, 0); push1(48'h44, 1);
    send_cfg();
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
